// File: rtl/pcs_types_pkg.sv
// Shared 10GBASE-R PCS receive types: block types, sync headers,
// XGMII characters and decoder state.
package pcs_types_pkg;

  localparam logic [7:0] BT_C  = 8'h1e;
  localparam logic [7:0] BT_S0 = 8'h78;
  localparam logic [7:0] BT_S4 = 8'h33;
  localparam logic [7:0] BT_O0 = 8'h4b;
  localparam logic [7:0] BT_T0 = 8'h87;
  localparam logic [7:0] BT_T1 = 8'h99;
  localparam logic [7:0] BT_T2 = 8'haa;
  localparam logic [7:0] BT_T3 = 8'hb4;
  localparam logic [7:0] BT_T4 = 8'hcc;
  localparam logic [7:0] BT_T5 = 8'hd2;
  localparam logic [7:0] BT_T6 = 8'he1;
  localparam logic [7:0] BT_T7 = 8'hff;

  localparam logic [1:0] SH_DATA = 2'b10;
  localparam logic [1:0] SH_CTRL = 2'b01;

  localparam logic [7:0] IDLE  = 8'h07;
  localparam logic [7:0] START = 8'hfb;
  localparam logic [7:0] TERM  = 8'hfd;
  localparam logic [7:0] ERROR = 8'hfe;
  localparam logic [7:0] SEQ   = 8'h9c;

  localparam logic [63:0] LF_WORD  = 64'h0100009c0100009c;
  localparam logic [7:0]  LF_CTL   = 8'h11;
  localparam logic [63:0] ERR_WORD = {8{ERROR}};

  typedef enum logic [1:0] {
    S_INIT,
    S_IDLE,
    S_DATA
  } dec_state_e;

  typedef enum logic [2:0] {
    BC_DATA,
    BC_CTRL,
    BC_START,
    BC_TERM,
    BC_INVALID
  } block_class_e;

endpackage

// File: rtl/decoder_6466b_block_map.sv
// Stateless 66b block to XGMII lane mapping with block classification.
// Sequencing is judged by the caller from block_class.
module decoder_6466b_block_map
  import pcs_types_pkg::*;
(
  input  logic [1:0]   header,
  input  logic [63:0]  data,
  output logic [63:0]  xgmii_data,
  output logic [7:0]   xgmii_ctl,
  output block_class_e block_class
);

  logic [7:0]  btype;
  logic [63:0] pay;
  logic [2:0]  tk;
  logic        is_term;

  assign btype = data[7:0];
  // payload byte j+1 lands at lane j
  assign pay = {8'h00, data[63:8]};

  always_comb begin
    xgmii_data  = ERR_WORD;
    xgmii_ctl   = 8'hff;
    block_class = BC_INVALID;
    is_term     = 1'b0;
    tk          = 3'd0;
    if (header == SH_DATA) begin
      xgmii_data  = data;
      xgmii_ctl   = 8'h00;
      block_class = BC_DATA;
    end else if (header == SH_CTRL) begin
      unique case (btype)
        BT_C: begin
          block_class = BC_CTRL;
          for (int n = 0; n < 8; n++) begin
            xgmii_data[8*n +: 8] =
              (data[8+7*n +: 7] == 7'h00) ? IDLE : ERROR;
          end
        end
        BT_S0: begin
          block_class = BC_START;
          xgmii_data  = {data[63:8], START};
          xgmii_ctl   = 8'h01;
        end
        BT_S4: begin
          block_class = BC_START;
          xgmii_data  = {data[63:40], START, {4{IDLE}}};
          xgmii_ctl   = 8'h1f;
        end
        BT_O0: begin
          block_class = BC_CTRL;
          xgmii_data  = {{4{IDLE}}, data[31:8], SEQ};
          xgmii_ctl   = 8'hf1;
        end
        BT_T0: begin is_term = 1'b1; tk = 3'd0; end
        BT_T1: begin is_term = 1'b1; tk = 3'd1; end
        BT_T2: begin is_term = 1'b1; tk = 3'd2; end
        BT_T3: begin is_term = 1'b1; tk = 3'd3; end
        BT_T4: begin is_term = 1'b1; tk = 3'd4; end
        BT_T5: begin is_term = 1'b1; tk = 3'd5; end
        BT_T6: begin is_term = 1'b1; tk = 3'd6; end
        BT_T7: begin is_term = 1'b1; tk = 3'd7; end
        default: ;
      endcase
      if (is_term) begin
        block_class = BC_TERM;
        xgmii_ctl   = 8'hff << tk;
        for (int i = 0; i < 8; i++) begin
          if (i < int'(tk))
            xgmii_data[8*i +: 8] = pay[8*i +: 8];
          else if (i == int'(tk))
            xgmii_data[8*i +: 8] = TERM;
          else
            xgmii_data[8*i +: 8] = IDLE;
        end
      end
    end
  end

endmodule

// File: rtl/decoder_6466b.sv
// 10GBASE-R receive 64b/66b decoder: frame sequencing FSM,
// registered XGMII outputs and saturating decode-error counter.
module decoder_6466b
  import pcs_types_pkg::*;
#(
  parameter int ERR_CNT_W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [63:0]          i_rx_data,
  input  logic [1:0]           i_rx_header,
  input  logic                 i_rx_valid,
  input  logic                 i_block_lock,
  input  logic                 i_err_clear,
  output logic [63:0]          o_xgmii_data,
  output logic [7:0]           o_xgmii_ctl,
  output logic                 o_xgmii_valid,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  dec_state_e   state, state_nxt;
  block_class_e cls;
  logic [63:0]  map_data;
  logic [7:0]   map_ctl;
  logic         err;
  logic         adv;
  logic         cnt_inc;

  decoder_6466b_block_map u_map (
    .header      (i_rx_header),
    .data        (i_rx_data),
    .xgmii_data  (map_data),
    .xgmii_ctl   (map_ctl),
    .block_class (cls)
  );

  assign adv     = i_rx_valid & i_block_lock;
  assign cnt_inc = adv & err & (o_err_count != '1);

  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    case (state)
      S_INIT, S_IDLE: begin
        unique case (cls)
          BC_CTRL:  state_nxt = S_IDLE;
          BC_START: state_nxt = S_DATA;
          default:  err = 1'b1;
        endcase
      end
      S_DATA: begin
        unique case (cls)
          BC_DATA: state_nxt = S_DATA;
          BC_TERM: state_nxt = S_IDLE;
          default: begin
            err       = 1'b1;
            state_nxt = S_IDLE;
          end
        endcase
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state         <= S_INIT;
      o_xgmii_data  <= LF_WORD;
      o_xgmii_ctl   <= LF_CTL;
      o_xgmii_valid <= 1'b0;
      o_err_count   <= '0;
    end else begin
      o_xgmii_valid <= i_rx_valid;
      if (i_rx_valid && !i_block_lock) begin
        state        <= S_INIT;
        o_xgmii_data <= LF_WORD;
        o_xgmii_ctl  <= LF_CTL;
      end else if (adv) begin
        state        <= state_nxt;
        o_xgmii_data <= err ? ERR_WORD : map_data;
        o_xgmii_ctl  <= err ? 8'hff : map_ctl;
      end
      if (i_err_clear)
        o_err_count <= '0;
      else if (cnt_inc)
        o_err_count <= o_err_count + ERR_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_decoder_6466b.sv
// Directed-vector bench for decoder_6466b with hand-computed
// expected XGMII words and error counts.
module tb_decoder_6466b;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [63:0] i_rx_data = '0;
  logic [1:0]  i_rx_header = 2'b00;
  logic        i_rx_valid = 1'b0;
  logic        i_block_lock = 1'b0;
  logic        i_err_clear = 1'b0;
  logic [63:0] o_xgmii_data;
  logic [7:0]  o_xgmii_ctl;
  logic        o_xgmii_valid;
  logic [15:0] o_err_count;

  int total = 0;
  int bad = 0;

  localparam logic [63:0] ERRW = 64'hfefefefefefefefe;
  localparam logic [63:0] LFW  = 64'h0100009c0100009c;

  decoder_6466b #(.ERR_CNT_W(16)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_rx_data     (i_rx_data),
    .i_rx_header   (i_rx_header),
    .i_rx_valid    (i_rx_valid),
    .i_block_lock  (i_block_lock),
    .i_err_clear   (i_err_clear),
    .o_xgmii_data  (o_xgmii_data),
    .o_xgmii_ctl   (o_xgmii_ctl),
    .o_xgmii_valid (o_xgmii_valid),
    .o_err_count   (o_err_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] h, input logic [63:0] d,
                       input logic v, input logic lk, input logic clr);
    i_rx_header  = h;
    i_rx_data    = d;
    i_rx_valid   = v;
    i_block_lock = lk;
    i_err_clear  = clr;
    @(posedge i_clk);
    #1;
    i_err_clear = 1'b0;
  endtask

  task automatic blk(input logic [1:0] h, input logic [63:0] d);
    drive(h, d, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic expect_out(input string tag, input logic [63:0] d,
                            input logic [7:0] c, input logic v,
                            input logic [15:0] n);
    chk({tag, ".data"}, o_xgmii_data, d);
    chk({tag, ".ctl"}, {56'h0, o_xgmii_ctl}, {56'h0, c});
    chk({tag, ".valid"}, {63'h0, o_xgmii_valid}, {63'h0, v});
    chk({tag, ".cnt"}, {48'h0, o_err_count}, {48'h0, n});
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    expect_out("reset", LFW, 8'h11, 1'b0, 16'd0);
    i_reset = 1'b0;

    blk(2'b01, 64'h000000000000001e);
    expect_out("idle", 64'h0707070707070707, 8'hff, 1'b1, 16'd0);
    // latency: new input is not visible before the next edge
    i_rx_header = 2'b01;
    i_rx_data   = 64'hd555555555555578;
    #3;
    chk("lat.hold", o_xgmii_data, 64'h0707070707070707);
    @(posedge i_clk);
    #1;
    expect_out("s0", 64'hd5555555555555fb, 8'h01, 1'b1, 16'd0);
    blk(2'b10, 64'h8b0e380577200008);
    expect_out("d0", 64'h8b0e380577200008, 8'h00, 1'b1, 16'd0);
    for (int i = 1; i < 8; i++) begin
      blk(2'b10, 64'h1111111100000000 + 64'(i));
      chk("dN", o_xgmii_data, 64'h1111111100000000 + 64'(i));
    end
    blk(2'b01, 64'h0000000000000087);
    expect_out("t0", 64'h07070707070707fd, 8'hff, 1'b1, 16'd0);

    blk(2'b10, 64'h0123456789abcdef);
    expect_out("data_in_idle", ERRW, 8'hff, 1'b1, 16'd1);

    blk(2'b01, 64'h0706050403020178);
    expect_out("s0b", 64'h07060504030201fb, 8'h01, 1'b1, 16'd1);
    blk(2'b01, 64'h00000000332211b4);
    expect_out("t3", 64'h07070707fd332211, 8'hf8, 1'b1, 16'd1);

    blk(2'b01, 64'h0000000000000078);
    blk(2'b01, 64'h0000000000000078);
    expect_out("start_in_data", ERRW, 8'hff, 1'b1, 16'd2);
    blk(2'b11, 64'h0000000000000000);
    expect_out("hdr11", ERRW, 8'hff, 1'b1, 16'd3);

    blk(2'b01, 64'h00000000ccbbaa4b);
    expect_out("oset", 64'h07070707ccbbaa9c, 8'hf1, 1'b1, 16'd3);
    blk(2'b01, 64'h6655440000000033);
    expect_out("s4", 64'h665544fb07070707, 8'h1f, 1'b1, 16'd3);
    blk(2'b01, 64'h77665544332211ff);
    expect_out("t7", 64'hfd77665544332211, 8'h80, 1'b1, 16'd3);
    blk(2'b01, 64'h000000000000011e);
    expect_out("ctl_bad_code", 64'h07070707070707fe, 8'hff, 1'b1, 16'd3);

    drive(2'b10, 64'h5555555555555555, 1'b1, 1'b0, 1'b0);
    expect_out("nolock", LFW, 8'h11, 1'b1, 16'd3);
    blk(2'b10, 64'h5555555555555555);
    expect_out("relock_data", ERRW, 8'hff, 1'b1, 16'd4);

    blk(2'b01, 64'h0000000000000078);
    blk(2'b10, 64'haaaaaaaa00000001);
    drive(2'b11, 64'h0, 1'b0, 1'b1, 1'b0);
    expect_out("gap", 64'haaaaaaaa00000001, 8'h00, 1'b0, 16'd4);
    blk(2'b10, 64'haaaaaaaa00000002);
    expect_out("after_gap", 64'haaaaaaaa00000002, 8'h00, 1'b1, 16'd4);
    blk(2'b01, 64'h0000000000000087);
    expect_out("gap_term", 64'h07070707070707fd, 8'hff, 1'b1, 16'd4);

    drive(2'b01, 64'h1e, 1'b0, 1'b1, 1'b1);
    chk("clear", {48'h0, o_err_count}, 64'd0);
    blk(2'b01, 64'h0000000000000000);
    expect_out("bad_type", ERRW, 8'hff, 1'b1, 16'd1);
    drive(2'b10, 64'h0, 1'b1, 1'b1, 1'b1);
    expect_out("clear_wins", ERRW, 8'hff, 1'b1, 16'd0);

    i_rx_header = 2'b11;
    i_rx_valid  = 1'b1;
    for (int i = 0; i < 65539; i++) @(posedge i_clk);
    #1;
    chk("saturate", {48'h0, o_err_count}, 64'h000000000000ffff);

    blk(2'b01, 64'h0000000000000078);
    #2;
    i_reset = 1'b1;
    #1;
    expect_out("async_rst", LFW, 8'h11, 1'b0, 16'd0);
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    blk(2'b10, 64'h0000000000000000);
    expect_out("post_rst_data", ERRW, 8'hff, 1'b1, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_6466b.md
Name: decoder_6466b

Overview:
- Receive-side 64b/66b block decoder for the 10GBASE-R PCS. It is the inverse of the transmit encoder.
- Takes descrambled 64-bit blocks plus the 2-bit sync header from the RX gearbox and block-lock logic.
- Emits 64-bit XGMII data with an 8-bit per-lane control mask to the MAC RX path.
- Enforces frame sequencing (start/data/terminate), substitutes error characters, and counts decode errors.

Parameters:
- ERR_CNT_W, 16, width of the saturating decode-error counter.

Ports:
- i_clk  input  1  PCS RX clock.
- i_reset  input  1  asynchronous, active-high reset.
- i_rx_data  input  64  descrambled block payload; block type is in bits [7:0].
- i_rx_header  input  2  sync header: 2'b10 = data block, 2'b01 = control block.
- i_rx_valid  input  1  block valid from the gearbox; low on gearbox slip cycles.
- i_block_lock  input  1  block lock achieved.
- o_xgmii_data  output  64  XGMII RX data; lane n occupies bits [8n+7:8n].
- o_xgmii_ctl  output  8  XGMII RX control; bit n corresponds to lane n.
- o_xgmii_valid  output  1  output word valid.
- o_err_count  output  ERR_CNT_W  saturating count of error blocks emitted.
- i_err_clear  input  1  synchronous clear of o_err_count.

Behaviour:
- Reset values:
  - o_xgmii_data = 64'h0100009c0100009c (local fault).
  - o_xgmii_ctl = 8'b00010001.
  - o_xgmii_valid = 0.
  - o_err_count = 0.
  - state = S_INIT.
- Latency: exactly 1 cycle from i_rx_valid to o_xgmii_valid. All outputs are registered.
- i_rx_valid = 0: o_xgmii_valid drops to 0 next cycle; data, ctl and state are held.
- i_block_lock = 0 with valid: output the local-fault word (64'h0100009c0100009c / 8'b00010001), state goes to S_INIT, no error counted.
- Block classification:
  - Header 2'b10: data block. Output = i_rx_data, ctl = 8'h00.
  - Header 2'b01: control block, decoded by i_rx_data[7:0]:
    - 0x1e: all-control. Each 7-bit code at bits [8+7n+6 : 8+7n] maps 0x00 → 0x07 (idle), anything else → 0xFE. ctl = 8'hff.
    - 0x78: start in lane 0. Lane0 = 0xFB, lanes 1–7 = payload bytes 1–7, ctl = 8'h01.
    - 0x33: lanes 0–3 idle, lane4 = 0xFB, lanes 5–7 = payload bytes 5–7, ctl = 8'h1f.
    - 0x87, 0x99, 0xaa, 0xb4, 0xcc, 0xd2, 0xe1, 0xff: terminate in lane k = 0..7 respectively.
      - Lanes 0..k-1 = payload bytes 1..k.
      - Lane k = 0xFD.
      - Lanes above k = 0x07.
      - ctl = 8'hff << k.
    - 0x4b: ordered set. Lane0 = 0x9C, lanes 1–3 = payload bytes 1–3, lanes 4–7 = 0x07, ctl = 8'hf1.
    - Any other type: invalid.
  - Header 2'b00 or 2'b11: invalid.
- Error block: all lanes 0xFE, ctl = 8'hff. o_err_count increments, saturating at all-ones.
- State machine (advances only on i_rx_valid & i_block_lock):
  - S_INIT:
    - Control/idle/ordered set → S_IDLE.
    - Start → S_DATA.
    - Data or terminate → error, stay in S_INIT.
  - S_IDLE:
    - Control/idle/ordered set → stay.
    - Start → S_DATA.
    - Data or terminate → error, stay in S_IDLE.
  - S_DATA:
    - Data → stay.
    - Terminate → S_IDLE.
    - Start, all-control or ordered set → error, S_IDLE.
  - Invalid header or type in any state → error. From S_DATA go to S_IDLE; other states are held.
- i_err_clear and an increment in the same cycle: clear wins, count = 0.
- i_reset asserted mid-frame: immediate return to reset values. The first post-reset data block is an error.

Decomposition:
- Package pcs_types_pkg holds:
  - Block-type constants (BT_C = 8'h1e, BT_S0 = 8'h78, BT_S4 = 8'h33, BT_O0 = 8'h4b, BT_T0..BT_T7).
  - Sync-header constants (SH_DATA = 2'b10, SH_CTRL = 2'b01).
  - XGMII characters (IDLE = 8'h07, START = 8'hfb, TERM = 8'hfd, ERROR = 8'hfe, SEQ = 8'h9c).
  - The local-fault word and a decoder state enum.
- One combinational sub-module, decoder_6466b_block_map: maps {header, data} → {xgmii_data, xgmii_ctl, block_class}. The top holds the FSM, output registers and counter.

Test Plan:
- Idle/start/data sequence:
  - Locked: hdr 01 / data 0x1e → 64'h0707070707070707 / ff.
  - Then 01 / 64'hd555555555555578 → 64'hd5555555555555fb / 01.
  - Then 10 / 64'h8b0e380577200008 → passthrough / 00.
  - Each output appears 1 cycle later.
- Full frame of eight data blocks ending with 01 / 64'h0000000000000087 → 64'h07070707070707fd / ff. State ends in S_IDLE; o_err_count = 0.
- Terminate T3 (0xb4), payload bytes 1–3 = 11, 22, 33 → lanes 0–2 = 11 22 33, lane3 = fd, ctl = 8'hf8.
- Sequencing errors:
  - Data block in S_IDLE → fefefefefefefefe / ff, count = 1.
  - Start received while in S_DATA → error word, count = 2.
  - Header 2'b11 → error word, count = 3.
- i_block_lock = 0 → local-fault word 0100009c0100009c / 11. Relock followed by a data block → error.
- i_rx_valid low for 1 cycle mid-frame → o_xgmii_valid = 0 that cycle, outputs held, frame continues with no errors.
- Counter: force 2^16+3 errors → o_err_count = 16'hffff. i_err_clear → 0.
